// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared types and constants for the 2-digit 7-segment count
//                scanner: scan FSM states, digit/segment vector types and the
//                active-high gfedcba glyph table.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Scan FSM states; each digit is preceded by an all-off blanking slot.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BLANK0 = 3'd1,
        ST_SHOW0  = 3'd2,
        ST_BLANK1 = 3'd3,
        ST_SHOW1  = 3'd4
    } state_t;

    typedef logic [3:0] digit_t;
    typedef logic [6:0] seg_t;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam seg_t SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    localparam seg_t SEG_OFF = 7'h00;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decoder
//  Description : Combinational BCD digit to active-high 7-segment pattern.
//                Non-decimal codes (10..15) produce a dark digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Table lookup; anything outside 0..9 stays blank.
    always_comb begin
        seg = SEG_OFF;
        case (digit)
            4'd0:    seg = SEG_DIGIT[0];
            4'd1:    seg = SEG_DIGIT[1];
            4'd2:    seg = SEG_DIGIT[2];
            4'd3:    seg = SEG_DIGIT[3];
            4'd4:    seg = SEG_DIGIT[4];
            4'd5:    seg = SEG_DIGIT[5];
            4'd6:    seg = SEG_DIGIT[6];
            4'd7:    seg = SEG_DIGIT[7];
            4'd8:    seg = SEG_DIGIT[8];
            4'd9:    seg = SEG_DIGIT[9];
            default: seg = SEG_OFF;
        endcase
    end

endmodule : seg7_decoder
`default_nettype wire

// File: rtl/seg7_count_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_count_scanner
//  Description : Shows a 4-bit count (0..15) as two decimal digits on a
//                multiplexed 2-digit 7-segment display. A scan FSM walks
//                BLANK0 -> SHOW0 -> BLANK1 -> SHOW1; count_in is snapshotted
//                once per frame so the display never tears.
//                Optional macro LEADING_ZERO_BLANK_EN: dark tens digit when 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_count_scanner #(
    parameter int CLK_DIV      = 4,
    parameter int BLANK_CYCLES = 1,
    parameter int ACTIVE_LOW   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] count_in,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] an,
    output logic       frame_done
);
    import seg7_pkg::*;

    localparam int c_MAX_SLOT = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int c_PW       = (c_MAX_SLOT > 1) ? $clog2(c_MAX_SLOT) : 1;
    localparam logic [c_PW-1:0] c_SHOW_LAST  = c_PW'(CLK_DIV - 1);
    localparam logic [c_PW-1:0] c_BLANK_LAST = c_PW'(BLANK_CYCLES - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [c_PW-1:0]   r_presc;
    logic [c_PW-1:0]   w_next_presc;
    digit_t            r_snap;
    digit_t            w_next_snap;
    seg_t              r_seg;
    seg_t              w_next_seg;
    logic [1:0]        r_an;
    logic [1:0]        w_next_an;
    logic              r_frame_done;
    logic              w_next_frame_done;
    logic              w_tens;
    digit_t            w_ones;
    digit_t            w_dec_in;
    seg_t              w_dec_seg;

    // Next-state / prescaler / snapshot; capture happens only on frame start.
    always_comb begin
        w_next_state = r_state;
        w_next_presc = r_presc + c_PW'(1);
        w_next_snap  = r_snap;
        case (r_state)
            ST_IDLE: begin
                w_next_presc = '0;
                if (enable) begin
                    w_next_state = ST_BLANK0;
                    w_next_snap  = count_in;
                end
            end
            ST_BLANK0: begin
                if (r_presc == c_BLANK_LAST) begin
                    w_next_state = ST_SHOW0;
                    w_next_presc = '0;
                end
            end
            ST_SHOW0: begin
                if (r_presc == c_SHOW_LAST) begin
                    w_next_state = ST_BLANK1;
                    w_next_presc = '0;
                end
            end
            ST_BLANK1: begin
                if (r_presc == c_BLANK_LAST) begin
                    w_next_state = ST_SHOW1;
                    w_next_presc = '0;
                end
            end
            ST_SHOW1: begin
                if (r_presc == c_SHOW_LAST) begin
                    w_next_presc = '0;
                    if (enable) begin
                        w_next_state = ST_BLANK0;
                        w_next_snap  = count_in;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_presc = '0;
            end
        endcase
    end

    // Split the upcoming snapshot into tens (0/1) and ones digits.
    always_comb begin
        w_tens   = (w_next_snap >= 4'd10);
        w_ones   = w_tens ? (w_next_snap - 4'd10) : w_next_snap;
        w_dec_in = (w_next_state == ST_SHOW1) ? {3'b000, w_tens} : w_ones;
    end

    seg7_decoder u_decoder (
        .digit (w_dec_in),
        .seg   (w_dec_seg)
    );

    // Output values for the upcoming state, so the registered outputs line up with it.
    always_comb begin
        w_next_an  = 2'b00;
        w_next_seg = SEG_OFF;
        case (w_next_state)
            ST_SHOW0: begin
                w_next_an  = 2'b01;
                w_next_seg = w_dec_seg;
            end
            ST_SHOW1: begin
`ifdef LEADING_ZERO_BLANK_EN
                if (w_tens) begin
                    w_next_an  = 2'b10;
                    w_next_seg = w_dec_seg;
                end
`else
                w_next_an  = 2'b10;
                w_next_seg = w_dec_seg;
`endif
            end
            default: begin
                w_next_an  = 2'b00;
                w_next_seg = SEG_OFF;
            end
        endcase
        w_next_frame_done = (w_next_state == ST_SHOW1) && (w_next_presc == c_SHOW_LAST);
    end

    // State and registered active-high outputs; async reset blanks the display at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_presc      <= '0;
            r_snap       <= '0;
            r_seg        <= SEG_OFF;
            r_an         <= 2'b00;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_presc      <= w_next_presc;
            r_snap       <= w_next_snap;
            r_seg        <= w_next_seg;
            r_an         <= w_next_an;
            r_frame_done <= w_next_frame_done;
        end
    end

    assign frame_done = r_frame_done;

    generate
        if (ACTIVE_LOW != 0) begin : g_active_low
            assign seg = ~r_seg;
            assign an  = ~r_an;
            assign dp  = 1'b1;
        end else begin : g_active_high
            assign seg = r_seg;
            assign an  = r_an;
            assign dp  = 1'b0;
        end
    endgenerate

endmodule : seg7_count_scanner
`default_nettype wire

// File: tb/tb_seg7_count_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_count_scanner
//  Description : Scoreboard bench for seg7_count_scanner. Two instances share
//                stimulus: an active-high build and an ACTIVE_LOW=1 build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_count_scanner;

    typedef struct {
        int         cyc;
        logic [1:0] an;
        logic [6:0] seg;
        logic       fd;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [3:0] count_in;
    logic [6:0] seg_h, seg_l;
    logic       dp_h, dp_l;
    logic [1:0] an_h, an_l;
    logic       fd_h, fd_l;

    int   cyc;
    int   n_vec;
    int   n_err;
    exp_t q[$];

    // Hand-written gfedcba glyphs 0..9
    logic [6:0] glyph [0:9];

    seg7_count_scanner #(.CLK_DIV(4), .BLANK_CYCLES(1), .ACTIVE_LOW(0)) u_dut_h (
        .clk(clk), .rst(rst), .enable(enable), .count_in(count_in),
        .seg(seg_h), .dp(dp_h), .an(an_h), .frame_done(fd_h)
    );

    seg7_count_scanner #(.CLK_DIV(4), .BLANK_CYCLES(1), .ACTIVE_LOW(1)) u_dut_l (
        .clk(clk), .rst(rst), .enable(enable), .count_in(count_in),
        .seg(seg_l), .dp(dp_l), .an(an_l), .frame_done(fd_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Compare one expected entry against both instances.
    task automatic check_entry(input exp_t e, input string tag);
        logic [10:0] act_h, req_h, act_l, req_l;
        act_h = {an_h, seg_h, fd_h, dp_h};
        req_h = {e.an, e.seg, e.fd, 1'b0};
        act_l = {an_l, seg_l, fd_l, dp_l};
        req_l = {~e.an, ~e.seg, e.fd, 1'b1};
        n_vec++;
        if (act_h !== req_h) begin
            n_err++;
            $display("FAIL %s_hi cyc=%0d actual an=%b seg=%h fd=%b dp=%b required an=%b seg=%h fd=%b dp=0",
                     tag, cyc, an_h, seg_h, fd_h, dp_h, e.an, e.seg, e.fd);
        end
        n_vec++;
        if (act_l !== req_l) begin
            n_err++;
            $display("FAIL %s_lo cyc=%0d actual an=%b seg=%h fd=%b dp=%b required an=%b seg=%h fd=%b dp=1",
                     tag, cyc, an_l, seg_l, fd_l, dp_l, ~e.an, ~e.seg, e.fd);
        end
    endtask

    // Monitor: pops every entry due on this cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc < cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL sched actual cyc=%0d required cyc=%0d", cyc, e.cyc);
            end else begin
                check_entry(e, "scan");
            end
        end
    end

    // Push one 10-cycle frame (CLK_DIV=4, BLANK_CYCLES=1) starting at capture edge e0.
    task automatic push_frame(input int e0, input int val);
        int   tens, ones;
        exp_t e;
        tens = (val >= 10) ? 1 : 0;
        ones = val - 10 * tens;
        for (int k = 0; k < 10; k++) begin
            e.cyc = e0 + k;
            e.an  = 2'b00;
            e.seg = 7'h00;
            e.fd  = (k == 9);
            if (k >= 1 && k <= 4) begin
                e.an  = 2'b01;
                e.seg = glyph[ones];
            end else if (k >= 6) begin
`ifdef LEADING_ZERO_BLANK_EN
                if (tens != 0) begin
                    e.an  = 2'b10;
                    e.seg = glyph[tens];
                end
`else
                e.an  = 2'b10;
                e.seg = glyph[tens];
`endif
            end
            q.push_back(e);
        end
    endtask

    task automatic push_idle(input int c0, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.cyc = c0 + k;
            e.an  = 2'b00;
            e.seg = 7'h00;
            e.fd  = 1'b0;
            q.push_back(e);
        end
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Watchdog
    initial begin
        #20000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t off;
        int   e0;
        int   x;
        glyph[0] = 7'h3F; glyph[1] = 7'h06; glyph[2] = 7'h5B; glyph[3] = 7'h4F;
        glyph[4] = 7'h66; glyph[5] = 7'h6D; glyph[6] = 7'h7D; glyph[7] = 7'h07;
        glyph[8] = 7'h7F; glyph[9] = 7'h6F;
        off.cyc = 0; off.an = 2'b00; off.seg = 7'h00; off.fd = 1'b0;
        cyc = 0; n_vec = 0; n_err = 0;
        rst = 1'b1; enable = 1'b0; count_in = 4'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check_entry(off, "reset");
        rst = 1'b0;

        // Frames 7, 13, 10 back-to-back
        @(negedge clk);
        enable = 1'b1; count_in = 4'd7;
        e0 = cyc + 1;
        push_frame(e0, 7);
        wait_until(e0 + 5);  count_in = 4'd13; push_frame(e0 + 10, 13);
        wait_until(e0 + 15); count_in = 4'd10; push_frame(e0 + 20, 10);
        wait_until(e0 + 25); count_in = 4'd14; push_frame(e0 + 30, 14);
        // Count steps 14 -> 15 -> 0 during SHOW0; frame stays "14"
        wait_until(e0 + 31); count_in = 4'd15;
        wait_until(e0 + 33); count_in = 4'd0;  push_frame(e0 + 40, 0);
        // Enable dropped mid-SHOW0: frame completes, then idle
        wait_until(e0 + 42); enable = 1'b0;
        push_idle(e0 + 50, 5);

        // New frame, then asynchronous reset during SHOW1
        wait_until(e0 + 55);
        enable = 1'b1; count_in = 4'd9;
        x = cyc + 1;
        push_frame(x, 9);
        wait_until(x + 7);
        #2 rst = 1'b1;
        #1 check_entry(off, "async_rst");
        q.delete();
        @(negedge clk);
        count_in = 4'd11;
        rst = 1'b0;
        x = cyc + 1;
        push_frame(x, 11);
        wait_until(x + 4); enable = 1'b0;
        push_idle(x + 10, 4);

        wait_until(x + 15);
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL leftover actual=%0d required=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_seg7_count_scanner
`default_nettype wire
